// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t        : controller states (IDLE, CALC, DONE)
//   DIV_W_DEFAULT  : default operand width, matching the 2x2 multiplier product
//   cnt_w()        : width of the bit counter for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_W_DEFAULT = 4;

    // Counter runs 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_i     : partial remainder before the step (always < divisor_i)
//   bit_i     : next dividend bit shifted in at the bottom
//   divisor_i : divisor
//   rem_o     : partial remainder after the step
//   qbit_o    : quotient bit produced by the step
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        // A non-negative trial difference is exactly shifted >= divisor.
        qbit_o  = (shifted >= {1'b0, divisor_i});
        // Since rem_i < divisor_i, a successful subtraction always fits in
        // WIDTH bits, and a restored value never has its top bit set.
        rem_o   = qbit_o ? WIDTH'(shifted - {1'b0, divisor_i})
                         : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake (dividend, divisor)
//   out_valid / out_ready : result handshake (quotient, remainder, div_by_zero)
// Divide by zero skips the iteration and returns all-ones / dividend with
// div_by_zero set. Only one operation is in flight at a time.
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] rem_d;
    logic             qbit_d;
    logic [WIDTH-1:0] quot_d;

    // quot_q doubles as the dividend shift register: its MSB feeds the step
    // and the new quotient bit enters at the LSB.
    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (quot_q[WIDTH-1]),
        .divisor_i(dvsr_q),
        .rem_o    (rem_d),
        .qbit_o   (qbit_d)
    );

    always_comb begin
        quot_d = {quot_q[WIDTH-2:0], qbit_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quot_q  <= dividend;
                            dvsr_q  <= divisor;
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end

                CALC: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Results become visible only when the last bit is done.
                    if (cnt_q == CNT_LAST) begin
                        quotient_q  <= quot_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        dbz_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
